// File: rtl/steer_en_pkg.sv
// Shared types and defaults for the rider-presence / steering-enable controller.
package steer_en_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } state_t;

    localparam logic [11:0] MIN_RIDER_WT_DEF  = 12'h200;
    localparam logic [7:0]  WT_HYSTERESIS_DEF = 8'h40;

    function automatic int unsigned tmr_width(input bit fast_sim);
        return fast_sim ? 32'd15 : 32'd26;
    endfunction

endpackage

// File: rtl/steer_en_cmp.sv
// Load-cell sum/difference and the four registered threshold flags.
module steer_en_cmp
    import steer_en_pkg::*;
#(
    parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
    parameter logic [7:0]  WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        sum_gt_min,
    output logic        sum_lt_min,
    output logic        diff_gt_1_4,
    output logic        diff_gt_15_16
);

    localparam logic [12:0] HI_THR = {1'b0, MIN_RIDER_WT} + {5'b0, WT_HYSTERESIS};
    localparam logic [12:0] LO_THR = {1'b0, MIN_RIDER_WT} - {5'b0, WT_HYSTERESIS};

    logic [12:0] sum;
    logic [12:0] diff;

    always_comb begin
        sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
        diff = (lft_ld >= rght_ld) ? {1'b0, lft_ld - rght_ld}
                                   : {1'b0, rght_ld - lft_ld};
    end

    // Sums exactly on a threshold set neither flag: they sit inside the hysteresis band.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_gt_min    <= 1'b0;
            sum_lt_min    <= 1'b0;
            diff_gt_1_4   <= 1'b0;
            diff_gt_15_16 <= 1'b0;
        end else begin
            sum_gt_min    <= (sum > HI_THR);
            sum_lt_min    <= (sum < LO_THR);
            diff_gt_1_4   <= (diff > (sum >> 2));
            diff_gt_15_16 <= (diff > (sum - (sum >> 4)));
        end
    end

endmodule

// File: rtl/steer_en_sm.sv
// Rider-presence FSM: enables steering after a balanced settle period,
// drops it on step-off or loss of weight.
module steer_en_sm
    import steer_en_pkg::*;
#(
    parameter bit          FAST_SIM      = 1'b0,
    parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
    parameter logic [7:0]  WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam int unsigned      TMR_W   = tmr_width(FAST_SIM);
    localparam logic [TMR_W-1:0] TMR_ONE = 1;

    logic sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;

    state_t           state, nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             tmr_full;

    steer_en_cmp #(
        .MIN_RIDER_WT (MIN_RIDER_WT),
        .WT_HYSTERESIS(WT_HYSTERESIS)
    ) u_cmp (
        .clk          (clk),
        .rst          (rst),
        .lft_ld       (lft_ld),
        .rght_ld      (rght_ld),
        .sum_gt_min   (sum_gt_min),
        .sum_lt_min   (sum_lt_min),
        .diff_gt_1_4  (diff_gt_1_4),
        .diff_gt_15_16(diff_gt_15_16)
    );

    assign tmr_full = &timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            state     <= nxt;
            timer     <= timer_nxt;
            en_steer  <= (nxt == STEER_EN);
            rider_off <= (nxt == IDLE);
        end
    end

    // One increment per balanced WAIT cycle, so the dwell is exactly 2^TMR_W cycles.
    always_comb begin
        nxt       = state;
        timer_nxt = timer;
        unique case (state)
            IDLE: begin
                if (sum_gt_min) begin
                    nxt       = WAIT;
                    timer_nxt = '0;
                end
            end
            WAIT: begin
                if (sum_lt_min) begin
                    nxt = IDLE;
                end else if (diff_gt_1_4) begin
                    timer_nxt = '0;
                end else if (tmr_full) begin
                    nxt = STEER_EN;
                end else begin
                    timer_nxt = timer + TMR_ONE;
                end
            end
            STEER_EN: begin
                if (sum_lt_min) begin
                    nxt = IDLE;
                end else if (diff_gt_15_16) begin
                    nxt       = WAIT;
                    timer_nxt = '0;
                end
            end
            default: begin
                nxt       = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_steer_en_sm.sv
// Directed bench for steer_en_sm with FAST_SIM=1 (32768-cycle settle).
module tb_steer_en_sm;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    int checks = 0;
    int errors = 0;

    steer_en_sm #(
        .FAST_SIM(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .en_steer (en_steer),
        .rider_off(rider_off)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic exp_en, input logic exp_off);
        chk({tag, ".en_steer"}, en_steer, exp_en);
        chk({tag, ".rider_off"}, rider_off, exp_off);
    endtask

    task automatic load(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
    endtask

    initial begin
        rst = 1'b1;
        load(12'h000, 12'h000);
        tick(4);
        chk_out("reset", 1'b0, 1'b1);

        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            chk_out("idle_empty", 1'b0, 1'b1);
        end

        // Mount, then reset part-way through the settle period.
        load(12'h300, 12'h300);
        tick(1);
        chk_out("mount_lat1", 1'b0, 1'b1);
        tick(1);
        chk_out("mount_lat2", 1'b0, 1'b0);
        tick(2999);
        rst = 1'b1;
        tick(1);
        chk_out("rst_midwait", 1'b0, 1'b1);
        rst = 1'b0;

        // Re-mount after reset: full settle time from WAIT entry.
        tick(1);
        chk_out("remount_lat1", 1'b0, 1'b1);
        tick(1);
        chk_out("remount_wait", 1'b0, 1'b0);
        tick(32767);
        chk_out("settle_early", 1'b0, 1'b0);
        tick(1);
        chk_out("settle_exact", 1'b1, 1'b0);

        // Steering survives moderate imbalance and in-band / boundary weight.
        load(12'h380, 12'h200);
        tick(10);
        chk_out("steer_mod_imb", 1'b1, 1'b0);
        load(12'h110, 12'h110);
        tick(10);
        chk_out("steer_hyst_220", 1'b1, 1'b0);
        load(12'h0E0, 12'h0E0);
        tick(10);
        chk_out("steer_bound_1c0", 1'b1, 1'b0);

        // Step-off: back to WAIT, rider still present.
        load(12'h600, 12'h010);
        tick(1);
        chk_out("stepoff_lat1", 1'b1, 1'b0);
        tick(1);
        chk_out("stepoff", 1'b0, 1'b0);

        // Imbalance inside WAIT restarts the settle count from the restore.
        load(12'h300, 12'h300);
        tick(200);
        chk_out("wait_pre_imb", 1'b0, 1'b0);
        load(12'h380, 12'h200);
        tick(100);
        chk_out("wait_imb", 1'b0, 1'b0);
        load(12'h300, 12'h300);
        tick(32768);
        chk_out("refill_early", 1'b0, 1'b0);
        tick(1);
        chk_out("refill_exact", 1'b1, 1'b0);

        // Weight below the low threshold drops straight to IDLE.
        load(12'h0D8, 12'h0D8);
        tick(1);
        chk_out("drop_lat1", 1'b1, 1'b0);
        tick(1);
        chk_out("drop_1b0", 1'b0, 1'b1);

        // In IDLE, in-band and boundary weight do not mount.
        load(12'h110, 12'h110);
        tick(10);
        chk_out("idle_hyst_220", 1'b0, 1'b1);
        load(12'h120, 12'h120);
        tick(10);
        chk_out("idle_bound_240", 1'b0, 1'b1);

        // Full-scale loads still register as a rider.
        load(12'hFFF, 12'hFFF);
        tick(2);
        chk_out("fullscale_mount", 1'b0, 1'b0);

        // Weight loss together with imbalance in WAIT: IDLE wins.
        load(12'h100, 12'h010);
        tick(1);
        chk_out("simul_lat1", 1'b0, 1'b0);
        tick(1);
        chk_out("simul_idle", 1'b0, 1'b1);
        tick(20);
        chk_out("simul_hold", 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
